video_fetch_multi: RTL and testbench
====================================

Name: video_fetch_multi

Overview:
- Parametrised successor of the fixed 4-word video fetcher.
- Gathers WORDS 16-bit words from the DRAM arbiter during each fetch period of 2^PER_LOG2 cend ticks.
- Presents them, byte-swapped, as one wide pic_bits word to the renderer on fetch_sync.
- Adds completeness checking (pic_valid, underrun, overrun), so bandwidth modes above 1/4 (WORDS=8, 16) are supported safely.

Parameters:
- WORDS, 4: words fetched per period; power of 2, range 2..16.
- PER_LOG2, 4: log2 of fetch period in cend ticks; range 3..6.
- PTR_W, $clog2(WORDS): fill pointer width; derived, do not override.

Ports:
- clk  in  1  28 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- cend  in  1  pixel-clock end strobe
- pre_cend  in  1  strobe one clk before cend
- vpix  in  1  vertical picture window
- fetch_start  in  1  fetch window start pulse
- fetch_end  in  1  fetch window end pulse
- video_data  in  16  word from DRAM arbiter
- video_strobe  in  1  video_data valid, 1 clk
- video_go  out  1  request for video bandwidth
- fetch_sync  out  1  period boundary pulse, coincides with cend
- pic_bits  out  16*WORDS  data to renderer
- pic_valid  out  1  pic_bits holds a complete period
- underrun  out  1  sticky: a period closed with fewer than WORDS strobes
- overrun  out  1  sticky: a strobe arrived with WORDS already stored
- err_clr  in  1  clears underrun, overrun and err_cnt
- err_cnt  out  8  saturating error counter (optional feature)

Behaviour:
- Reset (rst_n=0, async):
  - video_go, fetch_sync, pic_valid, underrun and overrun = 0; pic_bits = 0; err_cnt = 0.
  - Period counter = 0; fill pointer = 0; word count = 0.
- video_go: set on clk when fetch_start && vpix; else cleared when fetch_end. If both are set, the set wins.
- Period counter (PER_LOG2 bits): updates only on cend.
  - fetch_start -> 0; otherwise +1, wrapping at 2^PER_LOG2.
- fetch_sync: registered.
  - 1 for exactly one clk when pre_cend && counter==1 on the previous clk; lands on the cend clk.
- ptr_clr (internal, registered): 1 for one clk when pre_cend && counter==0.
- Fill state (pointer and count):
  - On ptr_clr: pointer -> 0, count -> 0.
  - If video_strobe occurs in the same clk as ptr_clr: the word is stored at index 0, pointer -> 1, count -> 1.
  - On video_strobe otherwise:
    - count<WORDS: store at buf[pointer], pointer +1 (wrapping mod WORDS), count +1.
    - count==WORDS: discard the word, set overrun; buffer and pointer unchanged.
- Latch into pic_bits: on the clk after fetch_sync (one-clk latency), for each i in 0..WORDS-1:
  - pic_bits[16i+7:16i] <= buf[i][15:8]
  - pic_bits[16i+15:16i+8] <= buf[i][7:0]
- pic_valid: updated with the same latch.
  - Equals (count==WORDS) && video_go, sampled on the fetch_sync clk.
- underrun: set on the fetch_sync clk when video_go=1 and count<WORDS.
  - Not set when video_go=0, i.e. when idle outside the window.
- Sticky flags: underrun and overrun hold until err_clr or reset.
  - err_clr has priority over a simultaneous set; the flag reads 0 the next clk.
- Mid-window fetch_start: counter resyncs to 0 and the buffer contents are kept. The next ptr_clr restarts filling.
- A strobe with video_go=0 is still stored; the arbiter is responsible for gating.

Optional Feature:
- Macro: VFETCH_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on every clk in which underrun or overrun would be set, counting each event even if the flag is already sticky.
  - An underrun and an overrun in the same clk count +1.
  - err_cnt saturates at 255 and is cleared by err_clr (clear wins).
- Undefined: err_cnt is constant 0 and no counter logic is synthesised.

Test Plan:
- Reset: assert rst_n=0 mid-period with video_go=1 and buffer half full -> all outputs 0 immediately, no clk needed; after release, first fetch_sync appears 2 cend ticks after the next fetch_start.
- WORDS=4, PER_LOG2=4: fetch_start&&vpix, strobes 0x1234,0x5678,0x9ABC,0xDEF0 in one period -> one clk after fetch_sync, pic_bits=0xF0DEBC9A78563412, pic_valid=1, underrun=0.
- WORDS=8: only 5 strobes in a period -> underrun=1, pic_valid=0; err_clr pulse -> underrun=0 next clk.
- WORDS=4: 6 strobes in a period -> words 5 and 6 dropped, pic_bits holds the first 4, overrun=1.
- video_strobe coincident with ptr_clr carrying 0xAA55 -> buf[0]=0xAA55, next strobe lands in buf[1]; fetch_sync spacing is exactly 16 cend ticks.
- VFETCH_ERRCNT_EN defined: 300 underrun periods -> err_cnt=255; err_clr together with a new error -> err_cnt=0.

Source files
------------

// File: rtl/video_fetch_multi.sv
// Gathers WORDS 16-bit DRAM words per fetch period and hands them byte-swapped to the renderer.
// Define VFETCH_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module video_fetch_multi #(
    parameter int WORDS    = 4,
    parameter int PER_LOG2 = 4,
    parameter int PTR_W    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cend,
    input  logic                  pre_cend,
    input  logic                  vpix,
    input  logic                  fetch_start,
    input  logic                  fetch_end,
    input  logic [15:0]           video_data,
    input  logic                  video_strobe,
    output logic                  video_go,
    output logic                  fetch_sync,
    output logic [16*WORDS-1:0]   pic_bits,
    output logic                  pic_valid,
    output logic                  underrun,
    output logic                  overrun,
    input  logic                  err_clr,
    output logic [7:0]            err_cnt
);

    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS);

    function automatic logic [15:0] byte_swap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    logic                  video_go_q,   video_go_d;
    logic [PER_LOG2-1:0]   per_cnt_q,    per_cnt_d;
    logic                  fetch_sync_q, fetch_sync_d;
    logic                  ptr_clr_q,    ptr_clr_d;
    logic [PTR_W-1:0]      ptr_q,        ptr_d;
    logic [CNT_W-1:0]      word_cnt_q,   word_cnt_d;
    logic [15:0]           wbuf_q [WORDS];
    logic [16*WORDS-1:0]   pic_bits_q,   pic_bits_d;
    logic                  pic_valid_q,  pic_valid_d;
    logic                  underrun_q,   underrun_d;
    logic                  overrun_q,    overrun_d;

    logic                  full_s;
    logic                  store_en_s;
    logic [PTR_W-1:0]      store_idx_s;
    logic                  underrun_ev_s;
    logic                  overrun_ev_s;

    // Bandwidth request, period counter and the two period strobes.
    always_comb begin
        video_go_d   = video_go_q;
        per_cnt_d    = per_cnt_q;
        if (fetch_start && vpix) begin
            video_go_d = 1'b1;
        end else if (fetch_end) begin
            video_go_d = 1'b0;
        end else begin
            video_go_d = video_go_q;
        end
        if (cend) begin
            if (fetch_start) begin
                per_cnt_d = '0;
            end else begin
                per_cnt_d = per_cnt_q + PER_LOG2'(1);
            end
        end else begin
            per_cnt_d = per_cnt_q;
        end
        fetch_sync_d = pre_cend && (per_cnt_q == PER_LOG2'(1));
        ptr_clr_d    = pre_cend && (per_cnt_q == PER_LOG2'(0));
    end

    // Fill pointer / word count; a strobe on the ptr_clr clk is the first word of the new period.
    always_comb begin
        full_s       = (word_cnt_q == FULL_CNT);
        ptr_d        = ptr_q;
        word_cnt_d   = word_cnt_q;
        store_en_s   = 1'b0;
        store_idx_s  = ptr_q;
        overrun_ev_s = 1'b0;
        if (ptr_clr_q) begin
            if (video_strobe) begin
                store_en_s  = 1'b1;
                store_idx_s = PTR_W'(0);
                ptr_d       = PTR_W'(1);
                word_cnt_d  = CNT_W'(1);
            end else begin
                ptr_d       = PTR_W'(0);
                word_cnt_d  = CNT_W'(0);
            end
        end else if (video_strobe) begin
            if (!full_s) begin
                store_en_s  = 1'b1;
                store_idx_s = ptr_q;
                ptr_d       = ptr_q + PTR_W'(1);
                word_cnt_d  = word_cnt_q + CNT_W'(1);
            end else begin
                overrun_ev_s = 1'b1;
            end
        end else begin
            ptr_d      = ptr_q;
            word_cnt_d = word_cnt_q;
        end
    end

    // Period close: latch the swapped buffer, judge completeness, update sticky flags.
    always_comb begin
        pic_bits_d    = pic_bits_q;
        pic_valid_d   = pic_valid_q;
        underrun_ev_s = fetch_sync_q && video_go_q && !full_s;
        if (fetch_sync_q) begin
            for (int i = 0; i < WORDS; i++) begin
                pic_bits_d[16*i +: 16] = byte_swap16(wbuf_q[i]);
            end
            pic_valid_d = full_s && video_go_q;
        end else begin
            pic_bits_d  = pic_bits_q;
            pic_valid_d = pic_valid_q;
        end
        if (err_clr) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            underrun_d = underrun_q || underrun_ev_s;
            overrun_d  = overrun_q  || overrun_ev_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_go_q   <= 1'b0;
            per_cnt_q    <= '0;
            fetch_sync_q <= 1'b0;
            ptr_clr_q    <= 1'b0;
            ptr_q        <= '0;
            word_cnt_q   <= '0;
            for (int i = 0; i < WORDS; i++) begin
                wbuf_q[i] <= 16'h0000;
            end
            pic_bits_q   <= '0;
            pic_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            video_go_q   <= video_go_d;
            per_cnt_q    <= per_cnt_d;
            fetch_sync_q <= fetch_sync_d;
            ptr_clr_q    <= ptr_clr_d;
            ptr_q        <= ptr_d;
            word_cnt_q   <= word_cnt_d;
            if (store_en_s) begin
                wbuf_q[store_idx_s] <= video_data;
            end
            pic_bits_q   <= pic_bits_d;
            pic_valid_q  <= pic_valid_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef VFETCH_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts every error event, even with the flag already sticky; clear wins, saturates at 255.
    always_comb begin
        if (err_clr) begin
            err_cnt_d = 8'h00;
        end else if ((underrun_ev_s || overrun_ev_s) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign video_go   = video_go_q;
    assign fetch_sync = fetch_sync_q;
    assign pic_bits   = pic_bits_q;
    assign pic_valid  = pic_valid_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_video_fetch_multi.sv
// Bench for video_fetch_multi (WORDS=4, PER_LOG2=4): directed scenarios plus random traffic,
// every clk compared against a period-level reference model.
module tb_video_fetch_multi;

    localparam int WORDS    = 4;
    localparam int PER_LOG2 = 4;
    localparam int PER      = 1 << PER_LOG2;
    localparam int GAP      = 8;
    localparam int PW       = 16 * WORDS;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            cend = 1'b0, pre_cend = 1'b0, vpix = 1'b0;
    logic            fetch_start = 1'b0, fetch_end = 1'b0;
    logic [15:0]     video_data = 16'h0000;
    logic            video_strobe = 1'b0, err_clr = 1'b0;
    logic            video_go, fetch_sync, pic_valid, underrun, overrun;
    logic [PW-1:0]   pic_bits;
    logic [7:0]      err_cnt;

    video_fetch_multi #(.WORDS(WORDS), .PER_LOG2(PER_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .cend(cend), .pre_cend(pre_cend), .vpix(vpix),
        .fetch_start(fetch_start), .fetch_end(fetch_end), .video_data(video_data),
        .video_strobe(video_strobe), .video_go(video_go), .fetch_sync(fetch_sync),
        .pic_bits(pic_bits), .pic_valid(pic_valid), .underrun(underrun), .overrun(overrun),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ph       = 0;
    bit start_req = 1'b0;

    bit          m_go, m_sync, m_clr, m_pv, m_und, m_ovr;
    int          m_cnt, m_wc, m_err;
    logic [15:0] m_buf [WORDS];
    logic [PW-1:0] m_pic;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] swap_all();
        logic [PW-1:0] r;
        for (int i = 0; i < WORDS; i++) r[16*i +: 16] = {m_buf[i][7:0], m_buf[i][15:8]};
        return r;
    endfunction

    function automatic int exp_err();
`ifdef VFETCH_ERRCNT_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_go = 0; m_sync = 0; m_clr = 0; m_pv = 0; m_und = 0; m_ovr = 0;
        m_cnt = 0; m_wc = 0; m_err = 0; m_pic = '0;
        for (int i = 0; i < WORDS; i++) m_buf[i] = 16'h0000;
    endtask

    task automatic model_step();
        bit go_n, und_ev, ovr_ev;
        int cnt_n;
        und_ev = 1'b0;
        ovr_ev = 1'b0;
        go_n  = (fetch_start && vpix) ? 1'b1 : (fetch_end ? 1'b0 : m_go);
        cnt_n = !cend ? m_cnt : (fetch_start ? 0 : (m_cnt + 1) % PER);
        if (m_sync) begin
            m_pic  = swap_all();
            m_pv   = (m_wc == WORDS) && m_go;
            und_ev = m_go && (m_wc < WORDS);
        end
        if (m_clr) m_wc = 0;
        if (video_strobe) begin
            if (m_wc < WORDS) begin
                m_buf[m_wc] = video_data;
                m_wc++;
            end else begin
                ovr_ev = 1'b1;
            end
        end
        m_sync = pre_cend && (m_cnt == 1);
        m_clr  = pre_cend && (m_cnt == 0);
        m_und  = !err_clr && (m_und || und_ev);
        m_ovr  = !err_clr && (m_ovr || ovr_ev);
        if (err_clr) m_err = 0;
        else if ((und_ev || ovr_ev) && m_err < 255) m_err++;
        m_go  = go_n;
        m_cnt = cnt_n;
    endtask

    task automatic check_all();
        chk("video_go",   64'(video_go),   64'(m_go));
        chk("fetch_sync", 64'(fetch_sync), 64'(m_sync));
        chk("pic_bits",   64'(pic_bits),   64'(m_pic));
        chk("pic_valid",  64'(pic_valid),  64'(m_pv));
        chk("underrun",   64'(underrun),   64'(m_und));
        chk("overrun",    64'(overrun),    64'(m_ovr));
        chk("err_cnt",    64'(err_cnt),    64'(exp_err()));
    endtask

    // One clk: cend/pre_cend come from the bench's phase, fetch_start waits for a cend.
    task automatic tick();
        cend        = (ph == GAP - 1);
        pre_cend    = (ph == GAP - 2);
        fetch_start = start_req && (ph == GAP - 1);
        @(posedge clk);
        model_step();
        ph = (ph + 1) % GAP;
        cyc++;
        #1;
        check_all();
        if (fetch_start) start_req = 1'b0;
        fetch_start  = 1'b0;
        video_strobe = 1'b0;
        err_clr      = 1'b0;
        fetch_end    = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        video_strobe = 1'b1;
        video_data   = d;
        tick();
    endtask

    task automatic do_start();
        int b = 0;
        start_req = 1'b1;
        while (start_req && b < 2 * GAP) begin tick(); b++; end
    endtask

    task automatic wait_clr();
        int b = 0;
        while (!m_clr && b < 400) begin tick(); b++; end
    endtask

    task automatic wait_sync();
        int b = 0;
        while (fetch_sync !== 1'b1 && b < 400) begin tick(); b++; end
        chk("sync_seen", 64'(fetch_sync), 64'(1));
    endtask

    logic [15:0]   w6 [6];
    logic [15:0]   r16;
    logic [PW-1:0] exp_pic;
    int            c0;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        chk("rst_video_go", 64'(video_go), 64'(0));
        chk("rst_pic_bits", 64'(pic_bits), 64'(0));
        chk("rst_err_cnt",  64'(err_cnt),  64'(0));
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        ph = 0;

        // Full period: 4 words, known swap pattern.
        vpix = 1'b1;
        do_start();
        wait_clr(); tick();
        send(16'h1234); send(16'h5678); send(16'h9ABC); send(16'hDEF0);
        wait_sync(); tick();
        chk("full_pic_bits",  64'(pic_bits),  64'hF0DEBC9A78563412);
        chk("full_pic_valid", 64'(pic_valid), 64'(1));
        chk("full_underrun",  64'(underrun),  64'(0));

        // Short period -> underrun, then err_clr.
        wait_clr(); tick();
        send(16'($urandom())); send(16'($urandom()));
        wait_sync(); tick();
        chk("short_underrun",  64'(underrun),  64'(1));
        chk("short_pic_valid", 64'(pic_valid), 64'(0));
        err_clr = 1'b1; tick();
        chk("clr_underrun", 64'(underrun), 64'(0));

        // Six strobes -> last two dropped.
        wait_clr(); tick();
        for (int i = 0; i < 6; i++) begin w6[i] = 16'($urandom()); send(w6[i]); end
        for (int i = 0; i < WORDS; i++) exp_pic[16*i +: 16] = {w6[i][7:0], w6[i][15:8]};
        wait_sync(); tick();
        chk("ovr_pic_bits",  64'(pic_bits),  64'(exp_pic));
        chk("ovr_flag",      64'(overrun),   64'(1));
        chk("ovr_pic_valid", 64'(pic_valid), 64'(1));
        err_clr = 1'b1; tick();
        chk("clr_overrun", 64'(overrun), 64'(0));

        // Strobe on the ptr_clr clk lands in word 0; then sync spacing.
        wait_clr();
        r16 = 16'($urandom());
        send(16'hAA55); send(r16);
        wait_sync(); c0 = cyc; tick();
        chk("coinc_w0", 64'(pic_bits[15:0]),  64'h55AA);
        chk("coinc_w1", 64'(pic_bits[31:16]), 64'({r16[7:0], r16[15:8]}));
        wait_sync();
        chk("sync_spacing", 64'(cyc - c0), 64'(PER * GAP));
        tick();

        // Async reset mid-period with video_go=1 and two words buffered.
        wait_clr(); tick();
        send(16'($urandom())); send(16'($urandom()));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_video_go",   64'(video_go),   64'(0));
        chk("arst_fetch_sync", 64'(fetch_sync), 64'(0));
        chk("arst_pic_bits",   64'(pic_bits),   64'(0));
        chk("arst_pic_valid",  64'(pic_valid),  64'(0));
        chk("arst_flags",      64'({underrun, overrun}), 64'(0));
        chk("arst_err_cnt",    64'(err_cnt),    64'(0));
        model_reset();
        @(posedge clk);
        ph = (ph + 1) % GAP;
        cyc++;
        #1 rst_n = 1'b1;
        do_start();
        c0 = cyc;
        wait_sync();
        // fetch_start cycle precedes c0 by one; sync lands two cend ticks after it
        chk("first_sync_delay", 64'(cyc - c0), 64'(2 * GAP - 1));
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            vpix         = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) start_req = 1'b1;
            fetch_end    = ($urandom_range(0, 399) == 0);
            video_strobe = ($urandom_range(0, 2) == 0);
            video_data   = 16'($urandom());
            err_clr      = ($urandom_range(0, 149) == 0);
            tick();
        end

        // 300 underrun periods saturate the counter; clear beats a new error.
        vpix = 1'b1;
        do_start();
        err_clr = 1'b1; tick();
        for (int p = 0; p < 300; p++) begin wait_sync(); tick(); end
`ifdef VFETCH_ERRCNT_EN
        chk("errcnt_sat", 64'(err_cnt), 64'(255));
`else
        chk("errcnt_off", 64'(err_cnt), 64'(0));
`endif
        wait_sync();
        err_clr = 1'b1; tick();
        chk("errcnt_clr_wins",   64'(err_cnt),  64'(0));
        chk("underrun_clr_wins", 64'(underrun), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
